interrupt_priority_controller: RTL and testbench
================================================

// Module: interrupt_priority_controller
// PURPOSE
//  Avalon-MM interrupt controller that sits between the raw interrupt capture lines and the CPU.
//  Per source it provides edge/level selection, pending latching, enable masking,
//  lowest-index-wins priority vectoring and a single registered IRQ to the processor.
//  Software services a source by reading VECTOR, then clearing it via ACK or PENDING write-1-to-clear.
// PARAMETERS
//  NUM_INTR  32  number of interrupt sources, legal range 1..32; unused upper bits read 0
// PORTS
//  csi_mem_clock_clock    in   1         single clock; all logic rising-edge
//  rsi_mem_reset_reset    in   1         synchronous, active-high reset
//  avs_mem_address        in   3         word address (map below)
//  avs_mem_read           in   1         read strobe, fixed 1-cycle read latency, no waitrequest
//  avs_mem_write          in   1         write strobe
//  avs_mem_writedata      in   32        write data
//  avs_mem_readdata       out  32        registered read data
//  irn_interrupt_irq      in   NUM_INTR  active-high interrupt sources
//  ins_irq_irq            out  1         active-high, registered IRQ to CPU
// BEHAVIOUR
//  Register map (word addr):
//   0 RAW     RO   sync_q (registered inputs)
//   1 PENDING RO/W1C  pending_q; write-1 clears edge-mode bits, level-mode bits ignore writes
//   2 ENABLE  RW   enable_q
//   3 EDGE    RW   edge_q; 1 = rising-edge latched, 0 = level
//   4 VECTOR  RO   {valid, 26'b0, idx[4:0]}; idx = lowest i with pending_q[i] & enable_q[i]
//   5 ACK     WO   writedata[4:0] = idx; clears pending_q[idx] if edge mode; idx>=NUM_INTR ignored
//   6,7 unmapped: reads return 0, writes ignored
//  Reset: sync_q, prev_q, pending_q, enable_q, edge_q, ins_irq_irq and avs_mem_readdata are all 0.
//   Reset mid-operation discards all pending state.
//  Pipeline: sync_q <= irq inputs; prev_q <= sync_q; rise = sync_q & ~prev_q.
//   Edge bit:  pending_q[i] <= (pending_q[i] & ~clr[i]) | rise[i]; set wins over clear in the same cycle.
//   Level bit: pending_q[i] <= sync_q[i], with no latching.
//   clr is the OR of the PENDING W1C mask and the ACK one-hot decode.
//  Latency: input high before edge E0 -> sync_q at E0 -> pending_q at E1 -> ins_irq_irq at E2.
//   ins_irq_irq <= |(pending_q & enable_q).
//  A source already high when reset deasserts counts as a rising edge on the first cycle (prev_q=0).
//  Disabling a source masks IRQ/VECTOR but does not clear its pending bit.
//  Changing EDGE from 1 to 0: the bit follows the level from the next edge on.
//  Reads: avs_mem_readdata <= read ? mux(address) : 0; data is valid the cycle after the read strobe.
//   Without a read strobe, readdata is 0.
//   VECTOR is sampled from pending_q/enable_q on the read cycle.
//  Simultaneous read and write at the same cycle: the read returns the pre-write value.
//  Writes take effect at the edge that samples avs_mem_write.
// TESTING
//  1. Reset with inputs=0 -> all regs read 0, ins_irq_irq=0, readdata=0 when idle.
//  2. EDGE=1, ENABLE=1, pulse irq[3] for 1 cycle -> PENDING=0x8 and IRQ high 2 edges after sample.
//     Then VECTOR=0x8000_0003; write ACK=3 -> PENDING=0, IRQ low the next cycle.
//  3. EDGE=0, ENABLE=0x5, hold irq[0], irq[2] high -> VECTOR idx=0.
//     Write PENDING=0x1 -> no change; drop irq[0] -> VECTOR idx=2 two cycles later.
//  4. EDGE=1, W1C PENDING bit5 in the same cycle as a new rise on irq[5] -> PENDING bit5 stays 1.
//  5. ENABLE=0 with irq[7] edge -> PENDING=0x80, IRQ=0, VECTOR valid=0.
//     Set ENABLE=0x80 -> IRQ high the next cycle.
//  6. Assert reset for 1 cycle while pending=0xFF -> all regs 0; input still high with EDGE=1 -> re-latched after release.

Source files
------------

// File: rtl/interrupt_priority_controller.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_priority_controller
//  Purpose  : Avalon-MM interrupt controller. Each source has an edge/level
//             select, a pending bit, an enable mask and lowest-index-wins
//             priority vectoring. A single registered IRQ goes to the CPU.
//             Software reads VECTOR, then clears the source through ACK or
//             a write-1-to-clear to PENDING.
//  Ports    : csi_mem_clock_clock  clock, rising edge
//             rsi_mem_reset_reset  synchronous active-high reset
//             avs_mem_address      word address (0 RAW, 1 PENDING, 2 ENABLE,
//                                  3 EDGE, 4 VECTOR, 5 ACK, 6/7 unmapped)
//             avs_mem_read         read strobe, 1-cycle read latency
//             avs_mem_write        write strobe
//             avs_mem_writedata    write data
//             avs_mem_readdata     registered read data, 0 when not reading
//             irn_interrupt_irq    active-high interrupt sources
//             ins_irq_irq          registered active-high IRQ to the CPU
//  Revision : 1.0  initial release
// ============================================================================
module interrupt_priority_controller #(
    parameter int NUM_INTR = 32
) (
    input  logic                csi_mem_clock_clock,
    input  logic                rsi_mem_reset_reset,
    input  logic [2:0]          avs_mem_address,
    input  logic                avs_mem_read,
    input  logic                avs_mem_write,
    input  logic [31:0]         avs_mem_writedata,
    output logic [31:0]         avs_mem_readdata,
    input  logic [NUM_INTR-1:0] irn_interrupt_irq,
    output logic                ins_irq_irq
);

    localparam logic [2:0] c_ADDR_RAW     = 3'd0;
    localparam logic [2:0] c_ADDR_PENDING = 3'd1;
    localparam logic [2:0] c_ADDR_ENABLE  = 3'd2;
    localparam logic [2:0] c_ADDR_EDGE    = 3'd3;
    localparam logic [2:0] c_ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] c_ADDR_ACK     = 3'd5;

    logic [NUM_INTR-1:0] r_sync;
    logic [NUM_INTR-1:0] r_prev;
    logic [NUM_INTR-1:0] r_pending;
    logic [NUM_INTR-1:0] r_enable;
    logic [NUM_INTR-1:0] r_edge;

    logic [NUM_INTR-1:0] w_rise;
    logic [NUM_INTR-1:0] w_ackHot;
    logic [NUM_INTR-1:0] w_clr;
    logic [NUM_INTR-1:0] w_pendNext;
    logic [NUM_INTR-1:0] w_active;
    logic [4:0]          w_idx;
    logic                w_valid;
    logic [31:0]         w_rdMux;
    logic                w_wrPending;
    logic                w_wrEnable;
    logic                w_wrEdge;
    logic                w_wrAck;

    assign w_wrPending = avs_mem_write && (avs_mem_address == c_ADDR_PENDING);
    assign w_wrEnable  = avs_mem_write && (avs_mem_address == c_ADDR_ENABLE);
    assign w_wrEdge    = avs_mem_write && (avs_mem_address == c_ADDR_EDGE);
    assign w_wrAck     = avs_mem_write && (avs_mem_address == c_ADDR_ACK);

    // prev starts at 0 after reset, so a source already high when reset
    // releases is seen as a rising edge.
    assign w_rise = r_sync & ~r_prev;

    // ACK one-hot decode. Only bits that exist are decoded, so an index at
    // or above NUM_INTR simply produces no clear.
    always_comb begin
        w_ackHot = '0;
        for (int i = 0; i < NUM_INTR; i++) begin
            w_ackHot[i] = w_wrAck && (avs_mem_writedata[4:0] == 5'(i));
        end
    end

    assign w_clr = w_ackHot | (w_wrPending ? avs_mem_writedata[NUM_INTR-1:0] : '0);

    // Edge bits latch rises (set beats clear); level bits just track sync.
    assign w_pendNext = (r_edge & ((r_pending & ~w_clr) | w_rise))
                      | (~r_edge & r_sync);

    assign w_active = r_pending & r_enable;

    // Scan from the top down so the lowest active index is the last writer.
    always_comb begin
        w_idx   = 5'd0;
        w_valid = 1'b0;
        for (int i = NUM_INTR - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_idx   = 5'(i);
                w_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdMux = '0;
        case (avs_mem_address)
            c_ADDR_RAW:     w_rdMux[NUM_INTR-1:0] = r_sync;
            c_ADDR_PENDING: w_rdMux[NUM_INTR-1:0] = r_pending;
            c_ADDR_ENABLE:  w_rdMux[NUM_INTR-1:0] = r_enable;
            c_ADDR_EDGE:    w_rdMux[NUM_INTR-1:0] = r_edge;
            c_ADDR_VECTOR:  w_rdMux = {w_valid, 26'b0, w_idx};
            default:        w_rdMux = '0;
        endcase
    end

    always_ff @(posedge csi_mem_clock_clock) begin
        if (rsi_mem_reset_reset) begin
            r_sync           <= '0;
            r_prev           <= '0;
            r_pending        <= '0;
            r_enable         <= '0;
            r_edge           <= '0;
            ins_irq_irq      <= 1'b0;
            avs_mem_readdata <= '0;
        end else begin
            r_sync      <= irn_interrupt_irq;
            r_prev      <= r_sync;
            r_pending   <= w_pendNext;
            ins_irq_irq <= |w_active;
            if (w_wrEnable) begin
                r_enable <= avs_mem_writedata[NUM_INTR-1:0];
            end
            if (w_wrEdge) begin
                r_edge <= avs_mem_writedata[NUM_INTR-1:0];
            end
            // Mux uses pre-write state, so a same-cycle read sees old data.
            avs_mem_readdata <= avs_mem_read ? w_rdMux : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_priority_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interrupt_priority_controller
//  Purpose  : Self-checking bench for interrupt_priority_controller with a
//             reference model, expected-read queue and decoupled monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interrupt_priority_controller;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [N-1:0] irq = '0;
    logic        cpuIrq;

    int checks = 0;
    int errors = 0;

    interrupt_priority_controller #(.NUM_INTR(N)) dut (
        .csi_mem_clock_clock (clk),
        .rsi_mem_reset_reset (rst),
        .avs_mem_address     (address),
        .avs_mem_read        (read),
        .avs_mem_write       (write),
        .avs_mem_writedata   (wdata),
        .avs_mem_readdata    (rdata),
        .irn_interrupt_irq   (irq),
        .ins_irq_irq         (cpuIrq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mSync = '0, mPrev = '0, mPend = '0, mEn = '0, mEdge = '0;
    logic        mIrq = 1'b0;
    logic [31:0] expQ[$];

    function automatic logic [31:0] modelRead(input logic [2:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            3'd0: v = mSync;
            3'd1: v = mPend;
            3'd2: v = mEn;
            3'd3: v = mEdge;
            3'd4: begin
                for (int i = 0; i < N; i++) begin
                    if (mPend[i] && mEn[i]) begin
                        v = 32'h8000_0000 + 32'(i);
                        break;
                    end
                end
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] clr;
        logic [31:0] nPend;
        if (rst) begin
            mSync = '0; mPrev = '0; mPend = '0; mEn = '0; mEdge = '0;
            mIrq  = 1'b0;
            expQ.delete();
        end else begin
            if (read) expQ.push_back(modelRead(address));
            clr = '0;
            if (write && address == 3'd1) clr = wdata;
            if (write && address == 3'd5 && int'(wdata[4:0]) < N) clr[wdata[4:0]] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (mEdge[i]) nPend[i] = (mSync[i] && !mPrev[i]) || (mPend[i] && !clr[i]);
                else          nPend[i] = mSync[i];
            end
            mIrq  = (mPend & mEn) != 0;
            mPrev = mSync;
            mSync = irq;
            mPend = nPend;
            if (write && address == 3'd2) mEn   = wdata;
            if (write && address == 3'd3) mEdge = wdata;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        checks++;
        if (cpuIrq !== mIrq) begin
            errors++;
            $display("FAIL irq_model t=%0t actual=%b required=%b", $time, cpuIrq, mIrq);
        end
        e = (expQ.size() > 0) ? expQ.pop_front() : 32'h0;
        checks++;
        if (rdata !== e) begin
            errors++;
            $display("FAIL readdata_model t=%0t actual=%h required=%h", $time, rdata, e);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic busRead(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = rdata;
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; wdata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] d;

    initial begin
        // 1. reset state
        idle(3);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            busRead(3'(a), d);
            check($sformatf("reset_reg%0d", a), d, 32'h0);
        end
        check("reset_irq", {31'b0, cpuIrq}, 32'h0);

        // 2. edge pulse on irq[3], vector, ACK
        busWrite(3'd3, 32'hFFFF_FFFF);
        busWrite(3'd2, 32'h0000_0008);
        @(negedge clk); irq = 32'h8;
        @(negedge clk); irq = 32'h0;
        idle(2);
        busRead(3'd1, d); check("t2_pending", d, 32'h8);
        busRead(3'd4, d); check("t2_vector", d, 32'h8000_0003);
        check("t2_irq_high", {31'b0, cpuIrq}, 32'h1);
        busWrite(3'd5, 32'd3);
        idle(1);
        check("t2_irq_low", {31'b0, cpuIrq}, 32'h0);
        busRead(3'd1, d); check("t2_pending_cleared", d, 32'h0);

        // 3. level mode priority
        busWrite(3'd3, 32'h0);
        busWrite(3'd2, 32'h5);
        irq = 32'h5;
        idle(3);
        busRead(3'd4, d); check("t3_vector0", d, 32'h8000_0000);
        busWrite(3'd1, 32'h1);
        busRead(3'd1, d); check("t3_level_w1c_ignored", d, 32'h5);
        irq = 32'h4;
        idle(2);
        busRead(3'd4, d); check("t3_vector2", d, 32'h8000_0002);

        // 4. set beats W1C in the same cycle
        irq = 32'h0;
        busWrite(3'd2, 32'h0);
        busWrite(3'd3, 32'hFFFF_FFFF);
        idle(2);
        busWrite(3'd1, 32'hFFFF_FFFF);
        @(negedge clk); irq = 32'h20;
        @(negedge clk); address = 3'd1; wdata = 32'h20; write = 1'b1;
        @(negedge clk); write = 1'b0;
        busRead(3'd1, d); check("t4_set_wins", d, 32'h20);

        // 5. masked source, then enable
        irq = 32'h0;
        busWrite(3'd1, 32'hFFFF_FFFF);
        @(negedge clk); irq = 32'h80;
        @(negedge clk); irq = 32'h0;
        idle(2);
        busRead(3'd1, d); check("t5_pending", d, 32'h80);
        busRead(3'd4, d); check("t5_vector_invalid", d, 32'h0);
        check("t5_irq_masked", {31'b0, cpuIrq}, 32'h0);
        busWrite(3'd2, 32'h80);
        idle(1);
        check("t5_irq_enabled", {31'b0, cpuIrq}, 32'h1);

        // 6. reset mid-operation, re-latch after release
        irq = 32'hFF;
        idle(3);
        busRead(3'd1, d); check("t6_pending_ff", d, 32'hFF);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("t6_irq_reset", {31'b0, cpuIrq}, 32'h0);
        busRead(3'd1, d); check("t6_pending_reset", d, 32'h0);
        busRead(3'd2, d); check("t6_enable_reset", d, 32'h0);
        busRead(3'd3, d); check("t6_edge_reset", d, 32'h0);
        busWrite(3'd3, 32'hFFFF_FFFF);
        idle(2);
        busRead(3'd1, d); check("t6_relatched", d, 32'hFF);

        // random phase, checked by the model/monitor
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) irq = irq ^ ($urandom & $urandom);
            address = 3'($urandom_range(0, 7));
            read    = ($urandom_range(0, 2) == 0);
            write   = ($urandom_range(0, 3) == 0);
            wdata   = (address == 3'd5) ? 32'($urandom_range(0, 31)) : $urandom;
        end
        @(negedge clk);
        rst = 1'b0; read = 1'b0; write = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
